// File: rtl/brg_pkg.sv
// Shared helpers for the baud-rate generator: chunk arithmetic, selector
// width, oversample counter width, reset values and a parameter sanity check.
package brg_pkg;

  // Reset values of the architectural state.
  localparam int RST_DIV    = 0;
  localparam int RST_CNT    = 0;
  localparam int RST_OS_CNT = 0;
  localparam logic RST_TICK = 1'b0;

  // Number of BUS_W-wide chunks that make up the divisor.
  function automatic int nchunk(input int div_w, input int bus_w);
    return (bus_w > 0) ? (div_w / bus_w) : 1;
  endfunction

  // Width of the chunk selector; never narrower than one bit.
  function automatic int sel_w(input int div_w, input int bus_w);
    int n;
    n = nchunk(div_w, bus_w);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the oversample counter; never narrower than one bit.
  function automatic int os_w(input int oversample);
    return (oversample <= 1) ? 1 : $clog2(oversample);
  endfunction

  // Elaboration-time check that the divisor splits into whole bus chunks.
  function automatic bit chunking_ok(input int div_w, input int bus_w);
    if (bus_w <= 0) return 1'b0;
    if (div_w < bus_w) return 1'b0;
    return (div_w % bus_w) == 0;
  endfunction

endpackage

// File: rtl/brg_downcnt.sv
// Generic reloadable down counter. reload wins over dec; zero flags a count
// of zero. RST_VAL sets the value taken while rst_n is low.
module brg_downcnt
  import brg_pkg::*;
#(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         reload,
  input  logic [W-1:0] reload_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Count register: reload has priority, otherwise decrement on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (reload) begin
      cnt <= reload_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/baud_gen.sv
// Baud-rate generator: chunked divisor load with commit on the top chunk,
// a sampling-rate tick every div_q cycles and a bit-rate bit_tick on every
// OVERSAMPLE-th tick.
// Optional feature macro: BAUD_GEN_BIT_TICK_EN. When undefined the oversample
// counter is not built and bit_tick is tied low (OVERSAMPLE is then unused).
//
// Handshake: load is a single-cycle write strobe with no ready; every cycle
// load is high one chunk is accepted. A write to the top chunk (index
// NCHUNK-1) commits {div_in, lower shadow chunks} to the active divisor.
module baud_gen
  import brg_pkg::*;
#(
  parameter  int DIV_W      = 16,
  parameter  int BUS_W      = 8,
  parameter  int OVERSAMPLE = 16,
  localparam int SEL_W      = sel_w(DIV_W, BUS_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SEL_W-1:0] load_sel,
  input  logic [BUS_W-1:0] div_in,
  input  logic             run,
  output logic [DIV_W-1:0] div_out,
  output logic             tick,
  output logic             bit_tick
);

  localparam int NCHUNK = nchunk(DIV_W, BUS_W);

  if (!chunking_ok(DIV_W, BUS_W)) begin : g_bad_div_w
    $error("baud_gen: DIV_W must be a non-zero multiple of BUS_W");
  end
  if (OVERSAMPLE < 1) begin : g_bad_oversample
    $error("baud_gen: OVERSAMPLE must be at least 1");
  end

  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] new_div;
  logic [DIV_W-1:0] cnt_reload_val;
  logic             commit;
  logic             active;
  logic             cnt_zero;
  logic             tick_now;
  logic             bit_now;

  // A single-chunk divisor has no meaningful selector: every load commits.
  if (NCHUNK == 1) begin : g_one_chunk
    assign commit = load;
  end else begin : g_multi_chunk
    assign commit = load && (load_sel == SEL_W'(NCHUNK - 1));
  end

  // Candidate divisor on a commit: top chunk from the bus, rest from shadow.
  always_comb begin
    new_div = shadow;
    new_div[DIV_W-1 -: BUS_W] = div_in;
  end

  // Shadow register collects the lower chunks; out-of-range selects are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= DIV_W'(RST_DIV);
    end else if (load) begin
      for (int i = 0; i < NCHUNK - 1; i++) begin
        if (load_sel == SEL_W'(i)) begin
          shadow[i*BUS_W +: BUS_W] <= div_in;
        end
      end
    end
  end

  // Counting only happens with run high, a non-zero divisor and no commit;
  // any other cycle reloads the counters and discards the partial period.
  assign active   = run && (div_q != '0) && !commit;
  assign tick_now = active && cnt_zero;

  // Reload value is divisor-1, saturating at 0 for a zero divisor.
  always_comb begin
    cnt_reload_val = '0;
    if (commit) begin
      if (new_div != '0) cnt_reload_val = new_div - DIV_W'(1);
    end else if (div_q != '0) begin
      cnt_reload_val = div_q - DIV_W'(1);
    end
  end

  brg_downcnt #(
    .W       (DIV_W),
    .RST_VAL (DIV_W'(RST_CNT))
  ) u_div_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .reload     (!active || cnt_zero),
    .reload_val (cnt_reload_val),
    .dec        (active),
    .zero       (cnt_zero)
  );

  // Active divisor and registered tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(RST_DIV);
      tick  <= RST_TICK;
    end else begin
      if (commit) div_q <= new_div;
      tick <= tick_now;
    end
  end

  assign div_out = div_q;

`ifdef BAUD_GEN_BIT_TICK_EN
  localparam int OS_W = os_w(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  // The oversample counter holds ticks remaining in the bit
  // (OVERSAMPLE-1-os_cnt), so bit_tick falls on its zero.
  logic os_zero;

  brg_downcnt #(
    .W       (OS_W),
    .RST_VAL (OS_W'(OVERSAMPLE - 1 - RST_OS_CNT))
  ) u_os_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .reload     (!active || (tick_now && os_zero)),
    .reload_val (OS_LAST),
    .dec        (tick_now),
    .zero       (os_zero)
  );

  assign bit_now = tick_now && os_zero;

  // Registered bit-rate pulse, aligned with its tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_tick <= RST_TICK;
    end else begin
      bit_tick <= bit_now;
    end
  end
`else
  assign bit_now  = 1'b0;
  assign bit_tick = bit_now;
`endif

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: a vector table for reset, chunked loads
// and the first tick, then hand-written sequences for periods, run drop,
// commit on the tick cycle, divisors 1 and 2 and asynchronous reset.
module tb_baud_gen;

  localparam int DIV_W      = 16;
  localparam int BUS_W      = 8;
  localparam int OVERSAMPLE = 16;

`ifdef BAUD_GEN_BIT_TICK_EN
  localparam bit BT_EN = 1'b1;
`else
  localparam bit BT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [0:0]       load_sel = 1'b0;
  logic [BUS_W-1:0] div_in = '0;
  logic             run = 1'b0;
  logic [DIV_W-1:0] div_out;
  logic             tick;
  logic             bit_tick;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        load;
    logic [0:0]  sel;
    logic [7:0]  din;
    logic        run;
    int          cycles;
    logic [15:0] exp_div;
    logic        exp_tick;
    logic        exp_bit;
  } vec_t;

  vec_t vecs[11];

  baud_gen #(
    .DIV_W      (DIV_W),
    .BUS_W      (BUS_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_sel (load_sel),
    .div_in   (div_in),
    .run      (run),
    .div_out  (div_out),
    .tick     (tick),
    .bit_tick (bit_tick)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // Driver and checker tasks.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!tick && n < max);
  endtask

  task automatic write_chunk(input logic [0:0] sel, input logic [7:0] d);
    load     = 1'b1;
    load_sel = sel;
    div_in   = d;
    step(1);
    load     = 1'b0;
  endtask

  // Scoreboard compare of a measured interval against the expected queue.
  task automatic check_gap(input string name, input int gap);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d expected <empty queue>", name, gap);
    end else begin
      e = exp_q.pop_front();
      check(name, gap, e);
    end
  endtask

  initial begin
    int n;
    int seen;

    vecs[0]  = '{1'b1, 1'b0, 8'h46, 1'b0,   1, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0,   2, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'h01, 1'b0,   1, 16'h0146, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h99, 1'b0,   1, 16'h0146, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h01, 1'b0,   1, 16'h0199, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h46, 1'b0,   1, 16'h0199, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'h01, 1'b0,   1, 16'h0146, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0,   3, 16'h0146, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 325, 16'h0146, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1,   1, 16'h0146, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1,   1, 16'h0146, 1'b0, 1'b0};

    // Reset held with run high.
    rst_n = 1'b0;
    run   = 1'b1;
    step(3);
    check("rst_tick", tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_div_out", div_out, 0);

    // Released with a zero divisor: no ticks at all.
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick || bit_tick) seen++;
    end
    check("div0_no_ticks", seen, 0);

    // Table: chunked loads, shadow isolation, first tick after run.
    for (int i = 0; i < 11; i++) begin
      load     = vecs[i].load;
      load_sel = vecs[i].sel;
      div_in   = vecs[i].din;
      run      = vecs[i].run;
      step(vecs[i].cycles);
      check($sformatf("vec%0d_div_out", i), div_out, vecs[i].exp_div);
      check($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
      check($sformatf("vec%0d_bit_tick", i), bit_tick, vecs[i].exp_bit);
    end
    load = 1'b0;

    // Periods at divisor 326: ticks #2..#17, bit_tick on the 16th tick.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'd326);
      wait_tick(700, n);
      check_gap($sformatf("period326_gap%0d", i), n + 1);
      check($sformatf("period326_bit%0d", i), bit_tick, (BT_EN && i == 14) ? 1 : 0);
      step(1);
      check($sformatf("period326_width%0d", i), tick, 0);
    end

    // Run dropped mid-period for 3 cycles: a full period after it returns.
    step(100);
    run = 1'b0;
    step(3);
    check("run_low_tick", tick, 0);
    run = 1'b1;
    exp_q.push_back(32'd326);
    wait_tick(700, n);
    check_gap("run_restart_gap", n);
    check("run_restart_bit", bit_tick, 0);

    // Commit of divisor 10 on the cycle where cnt is 0.
    write_chunk(1'b0, 8'h0A);
    step(324);
    check("pre_commit_tick", tick, 0);
    write_chunk(1'b1, 8'h00);
    check("commit_suppress_tick", tick, 0);
    check("commit_suppress_bit", bit_tick, 0);
    check("commit_div_out", div_out, 10);
    exp_q.push_back(32'd10);
    wait_tick(40, n);
    check_gap("commit10_first_gap", n);

    // Divisor 2: tick every other cycle, bit_tick every 32 cycles.
    write_chunk(1'b0, 8'h02);
    write_chunk(1'b1, 8'h00);
    check("div2_commit_tick", tick, 0);
    check("div2_div_out", div_out, 2);
    for (int k = 1; k <= 64; k++) begin
      step(1);
      check($sformatf("div2_tick_k%0d", k), tick, (k % 2 == 0) ? 1 : 0);
      check($sformatf("div2_bit_k%0d", k), bit_tick, (BT_EN && k % 32 == 0) ? 1 : 0);
    end

    // Divisor 1: tick constantly high, bit_tick every 16 cycles.
    write_chunk(1'b0, 8'h01);
    write_chunk(1'b1, 8'h00);
    check("div1_commit_tick", tick, 0);
    check("div1_div_out", div_out, 1);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      check($sformatf("div1_tick_k%0d", k), tick, 1);
      check($sformatf("div1_bit_k%0d", k), bit_tick, (BT_EN && k % 16 == 0) ? 1 : 0);
    end

    // Run low stops ticks immediately.
    run = 1'b0;
    step(1);
    check("div1_run_low_tick", tick, 0);
    step(1);
    check("div1_run_low_tick2", tick, 0);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    run = 1'b1;
    step(2);
    check("pre_async_rst_tick", tick, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tick", tick, 0);
    check("async_rst_bit_tick", bit_tick, 0);
    check("async_rst_div_out", div_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
